// File: rtl/dlx_icache_ctrl_pkg.sv
//============================================================================
// Module      : dlx_icache_ctrl_pkg
// Description : Shared constants and types for the DLX instruction cache.
//               The cache geometry defaults (line width, index, tag and
//               address widths) live here, so the controller's parameters
//               default to the same machine-wide values.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package dlx_icache_ctrl_pkg;

  // Machine-wide widths
  localparam int ADDRESS_WIDTH = 16;
  localparam int bw_word       = 32;
  localparam int bw_cacheline  = 128;
  localparam int bw_ic_index   = 5;

  // Cache geometry derived from the line width
  localparam int IC_WORDS_PER_LINE = bw_cacheline / bw_word;
  localparam int IC_OFFSET_BITS    = $clog2(bw_cacheline / 8);
  localparam int bw_ic_offset      = IC_OFFSET_BITS;
  localparam int bw_ic_tag         = ADDRESS_WIDTH - bw_ic_index - bw_ic_offset;

  // Miss-handling controller states
  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_FILL = 2'd2,
    IC_RESP = 2'd3
  } icache_state;

endpackage

`default_nettype wire

// File: rtl/dlx_icache_array.sv
//============================================================================
// Module      : dlx_icache_array
// Description : Tag/valid/data storage of the direct-mapped I-cache.
//               Combinational lookup port, one-word write port used by the
//               line fill, tag commit (which also sets the valid bit) and a
//               bulk clear of the valid bits.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dlx_icache_array
  import dlx_icache_ctrl_pkg::*;
#(
  parameter int WORD_W  = bw_word,
  parameter int WPL     = IC_WORDS_PER_LINE,
  parameter int INDEX_W = bw_ic_index,
  parameter int TAG_W   = bw_ic_tag,
  parameter int WSEL_W  = $clog2(WPL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  // lookup
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  input  logic [WSEL_W-1:0]  rd_word,
  output logic               rd_hit,
  output logic [WORD_W-1:0]  rd_data,
  // fill
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WSEL_W-1:0]  wr_word,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   wr_tag
);

  localparam int LINES = 2 ** INDEX_W;

  logic [WORD_W-1:0] r_data [LINES][WPL];
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINES-1:0]  r_valid;

  // Lookup is purely combinational so a hit can be registered in one cycle
  always_comb begin
    rd_hit  = r_valid[rd_index] && (r_tag[rd_index] == rd_tag);
    rd_data = r_data[rd_index][rd_word];
  end

  // Data and tag arrays carry no reset; only the valid bits qualify them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[wr_index][wr_word] <= wr_data;
    end
    if (tag_we) begin
      r_tag[wr_index] <= wr_tag;
    end
  end

  // Valid bits: reset and clear dominate over a simultaneous line commit
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_valid <= '0;
    end else if (tag_we) begin
      r_valid[wr_index] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dlx_icache_ctrl.sv
//============================================================================
// Module      : dlx_icache_ctrl
// Description : Parametrised direct-mapped instruction cache for the DLX
//               fetch stage. One-cycle hits, miss handling with a
//               request/ready handshake followed by an in-order burst of
//               fill beats, global flush and saturating hit/miss counters.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dlx_icache_ctrl
  import dlx_icache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDRESS_WIDTH,
  parameter int WORD_W  = bw_word,
  parameter int LINE_W  = bw_cacheline,
  parameter int INDEX_W = bw_ic_index,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [WORD_W-1:0] mem_rsp_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int WPL    = LINE_W / WORD_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  // Word-select width: offset bits above the byte-in-word bits [1:0]
  localparam int WSEL_W = OFF_W - 2;

  icache_state        r_state;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [WSEL_W-1:0]  r_word;
  logic [WSEL_W-1:0]  r_cnt;
  logic [WORD_W-1:0]  r_word_buf;
  logic               r_flush_pend;

  logic [WSEL_W-1:0]  w_req_word;
  logic [INDEX_W-1:0] w_req_index;
  logic [TAG_W-1:0]   w_req_tag;
  logic               w_hit;
  logic [WORD_W-1:0]  w_hit_data;
  logic               w_fill_we;
  logic               w_last_beat;
  logic               w_clear;
  logic               w_unused_addr_lsb;

  // Address split of the incoming fetch
  assign w_req_word  = cpu_addr[OFF_W-1:2];
  assign w_req_index = cpu_addr[OFF_W+INDEX_W-1:OFF_W];
  assign w_req_tag   = cpu_addr[ADDR_W-1:OFF_W+INDEX_W];
  assign w_unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

  assign w_fill_we   = (r_state == IC_FILL) && mem_rsp_valid;
  assign w_last_beat = w_fill_we && (r_cnt == WSEL_W'(WPL - 1));
  // A flush seen during a miss waits until the requested word is delivered
  assign w_clear     = ((r_state == IC_IDLE) && flush) ||
                       ((r_state == IC_RESP) && (r_flush_pend || flush));

  dlx_icache_array #(
    .WORD_W  (WORD_W),
    .WPL     (WPL),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .WSEL_W  (WSEL_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .rd_index (w_req_index),
    .rd_tag   (w_req_tag),
    .rd_word  (w_req_word),
    .rd_hit   (w_hit),
    .rd_data  (w_hit_data),
    .wr_en    (w_fill_we),
    .wr_index (r_index),
    .wr_word  (r_cnt),
    .wr_data  (mem_rsp_data),
    .tag_we   (w_last_beat),
    .wr_tag   (r_tag)
  );

  // Controller FSM with registered CPU/memory outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IC_IDLE;
      r_index       <= '0;
      r_tag         <= '0;
      r_word        <= '0;
      r_cnt         <= '0;
      r_word_buf    <= '0;
      r_flush_pend  <= 1'b0;
      cpu_rdata     <= '0;
      cpu_rvalid    <= 1'b0;
      cpu_stall     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      case (r_state)
        IC_IDLE: begin
          if (cpu_req_valid) begin
            // A flush in the same cycle invalidates the line being looked up
            if (w_hit && !flush) begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= w_hit_data;
              if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              r_index       <= w_req_index;
              r_tag         <= w_req_tag;
              r_word        <= w_req_word;
              r_flush_pend  <= 1'b0;
              cpu_stall     <= 1'b1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
              r_state       <= IC_REQ;
            end
          end
        end
        IC_REQ: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= IC_FILL;
          end
        end
        IC_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_rsp_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_word) r_word_buf <= mem_rsp_data;
            if (w_last_beat) begin
              // The requested word may be the final beat itself
              cpu_rdata  <= (r_cnt == r_word) ? mem_rsp_data : r_word_buf;
              cpu_rvalid <= 1'b1;
              cpu_stall  <= 1'b0;
              r_state    <= IC_RESP;
            end
          end
        end
        IC_RESP: begin
          r_flush_pend <= 1'b0;
          r_state      <= IC_IDLE;
        end
        default: r_state <= IC_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/dlx_icache_ctrl.md
Name: dlx_icache_ctrl

Overview:
- Parametrised direct-mapped instruction cache for the DLX fetch stage.
- Generalises the fixed shared cache constants (128-bit line, 5-bit index, 7-bit tag, 16-bit address) into module parameters.
- Adds a miss/line-fill state machine with a burst memory handshake, global flush and saturating hit/miss counters.
- Sits between the IF stage (word fetch) and the memory/bus interface.

Parameters:
- ADDR_W, 16, byte address width; default equals the shared address width.
- WORD_W, 32, instruction word width; must equal the DLX word size.
- LINE_W, 128, cache line width in bits; must be a power-of-two multiple of WORD_W.
- INDEX_W, 5, line index bits (2**INDEX_W lines).
- CNT_W, 16, width of the performance counters.
- Derived localparams:
  - WPL = LINE_W/WORD_W
  - OFF_W = log2(LINE_W/8)
  - TAG_W = ADDR_W-INDEX_W-OFF_W (7 at defaults)

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  fetch request this cycle.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] are ignored.
- cpu_rdata  out  WORD_W  fetched instruction word.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- cpu_stall  out  1  high while a miss is outstanding.
- flush  in  1  invalidate all lines.
- mem_req_valid  out  1  line-fill request.
- mem_req_addr  out  ADDR_W  line-aligned address; low OFF_W bits are zero.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  one fill word is present.
- mem_rsp_data  in  WORD_W  fill word; beats arrive in ascending word order.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Address split: word = addr[OFF_W-1:2]; index = addr[OFF_W+INDEX_W-1:OFF_W]; tag = addr[ADDR_W-1:OFF_W+INDEX_W].
- Storage: data, tag and valid arrays in flops. The valid array is the only one cleared by reset or flush.
- Reset (synchronous, rst=1), values applied at that clock edge:
  - State -> IDLE; all valid bits -> 0.
  - Outputs cpu_rvalid, cpu_stall, mem_req_valid, cpu_rdata, mem_req_addr and both counters -> 0.
  - An in-progress fill is abandoned; stray mem_rsp_valid beats arriving afterwards are ignored in IDLE.
- FSM states: IDLE, REQ, FILL, RESP.
- IDLE:
  - cpu_req_valid and hit: next cycle cpu_rvalid=1 with the word (latency 1); hit_cnt++. Back-to-back hits give one word per cycle.
  - cpu_req_valid and miss: latch addr; miss_cnt++; go to REQ. cpu_stall=1 from the next cycle.
- REQ: mem_req_valid=1 and mem_req_addr held stable until the cycle mem_req_ready=1; then go to FILL. Word counter -> 0.
- FILL:
  - Each mem_rsp_valid writes data[index][cnt] and increments cnt.
  - On beat WPL-1: write tag, set valid, go to RESP.
  - Gaps (mem_rsp_valid=0) are allowed indefinitely.
- RESP: cpu_rvalid=1 with the latched word from the filled line; cpu_stall=0; go to IDLE.
- cpu_req_valid is ignored outside IDLE. The IF stage holds its request while cpu_stall=1 and re-presents the next fetch after cpu_rvalid.
- Flush:
  - In IDLE: all valid bits clear at that edge. A cpu_req_valid in the same cycle is treated as a miss.
  - During REQ/FILL/RESP: flush is latched as pending. The requested word is still delivered in RESP, and the pending flush is applied on the RESP->IDLE edge, invalidating the just-filled line as well.
- Counters saturate at 2**CNT_W-1; no wrap-around.
- A conflict miss (same index, different tag) overwrites the line; no write-back is needed because the cache is read-only.

Decomposition:
- Shared package gains:
  - typedef enum {IC_IDLE, IC_REQ, IC_FILL, IC_RESP} icache_state
  - constants IC_WORDS_PER_LINE and IC_OFFSET_BITS derived from bw_cacheline
  - default-parameter defines mapped to bw_ic_offset, bw_ic_tag and ADDRESS_WIDTH
- One natural sub-module: dlx_icache_array, holding the tag/valid/data storage with a combinational lookup port, a word-write port, and a flush/clear input.

Test Plan:
- Cold miss: after reset, read 0x1234 (tag 0x09, idx 3, word 1) -> mem_req_addr=0x1230; 4 beats A0..A3 -> cpu_rvalid with A1; miss_cnt=1.
- Hit stream: reads 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles -> A0..A3 on consecutive cycles at latency 1, no stall; hit_cnt=4.
- Conflict: read 0x1434 (tag 0x0A, idx 3) -> refill with B0..B3, returns B1. A following read of 0x1234 misses again; miss_cnt=3.
- Backpressure/gaps: mem_req_ready held low 5 cycles, then fill beats with 1-cycle gaps -> mem_req_addr stable throughout, cpu_stall high throughout, correct word returned.
- Flush mid-fill: flush pulse after beat 2 -> the word is still returned; then a read of the same address misses.
- Reset mid-fill: rst during FILL -> all outputs 0 next cycle; a read of 0x1234 misses; stray beats are ignored.
- Saturation: CNT_W=2, 5 hits -> hit_cnt=3.
